// File: rtl/spi_follower.sv
// SPI follower endpoint: oversamples the leader's ext_clk/cs/in on clk, shifts a
// frame into rx_data and returns the CPU-loaded tx word on out. CPOL/CPHA 0-3, 8/16 bit.
module spi_follower #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ext_clk,
   input  logic        cs,
   input  logic        in,
   output logic        out,
   input  logic        cpol,
   input  logic        cpha,
   input  logic        len,
   input  logic [15:0] tx_data,
   input  logic        tx_load,
   output logic        tx_ready,
   output logic [15:0] rx_data,
   output logic        rx_valid,
   output logic        abort
);
   localparam int unsigned DW = 16;
   localparam int unsigned CW = 5;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACTIVE = 2'd1,
      DONE   = 2'd2
   } state_t;

   state_t state, state_nxt;

   logic [SYNC_STAGES-1:0] sclk_sync;
   logic [SYNC_STAGES-1:0] cs_sync;
   logic [SYNC_STAGES-1:0] din_sync;
   logic sclk_s, cs_s, din_s;
   logic sclk_q, cs_q;

   logic          cpol_l, cpha_l, len_l;
   logic [DW-1:0] tx_buf;
   logic [DW-1:0] tx_shift;
   logic [DW-1:0] tx_shifted;
   logic [DW-2:0] rx_shift;
   logic [DW-1:0] rx_next;
   logic [CW-1:0] bit_cnt;
   logic          first_lead;

   logic          sclk_edge, lead, trail, sample_ev, shift_ev;
   logic          cs_fall, cs_rise;
   logic          frame_last, frame_done;
   logic          load_frame, abort_c;
   logic          ent_cpha, ent_len;
   logic [DW-1:0] load_word;

   function automatic logic msb_of(input logic [DW-1:0] w, input logic l16);
      return l16 ? w[DW-1] : w[7];
   endfunction

   // Synchronizers; cs resets to its inactive (high) level
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sclk_sync <= '0;
         cs_sync   <= '1;
         din_sync  <= '0;
         sclk_q    <= 1'b0;
         cs_q      <= 1'b1;
      end else begin
         sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], ext_clk};
         cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs};
         din_sync  <= {din_sync[SYNC_STAGES-2:0], in};
         sclk_q    <= sclk_s;
         cs_q      <= cs_s;
      end
   end

   assign sclk_s = sclk_sync[SYNC_STAGES-1];
   assign cs_s   = cs_sync[SYNC_STAGES-1];
   assign din_s  = din_sync[SYNC_STAGES-1];

   assign sclk_edge = sclk_s ^ sclk_q;
   assign lead      = sclk_edge && (sclk_q == cpol_l);
   assign trail     = sclk_edge && (sclk_s == cpol_l);
   assign sample_ev = cpha_l ? trail : lead;
   assign shift_ev  = cpha_l ? lead : trail;
   assign cs_fall   = cs_q && !cs_s;
   assign cs_rise   = !cs_q && cs_s;

   assign frame_last = (bit_cnt == (len_l ? CW'(15) : CW'(7)));
   assign frame_done = (state == ACTIVE) && sample_ev && frame_last;
   assign rx_next    = {rx_shift, din_s};
   assign tx_shifted = {tx_shift[DW-2:0], 1'b0};

   // Config seen by a frame that starts this cycle (latch not yet updated from IDLE)
   assign ent_cpha  = (state == IDLE) ? cpha : cpha_l;
   assign ent_len   = (state == IDLE) ? len : len_l;
   assign load_word = tx_ready ? '0 : tx_buf;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next state; a cs release with no bit received yet is not an abort
   always_comb begin
      state_nxt  = state;
      load_frame = 1'b0;
      abort_c    = 1'b0;
      case (state)
         IDLE: begin
            if (cs_fall) begin
               state_nxt  = ACTIVE;
               load_frame = 1'b1;
            end
         end
         ACTIVE: begin
            if (frame_done) begin
               state_nxt = DONE;
            end else if (cs_rise) begin
               state_nxt = IDLE;
               abort_c   = (bit_cnt != '0) || sample_ev;
            end
         end
         DONE: begin
            if (!cs_s) begin
               state_nxt  = ACTIVE;
               load_frame = 1'b1;
            end else begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cpol_l     <= 1'b0;
         cpha_l     <= 1'b0;
         len_l      <= 1'b0;
         tx_buf     <= '0;
         tx_ready   <= 1'b1;
         tx_shift   <= '0;
         rx_shift   <= '0;
         bit_cnt    <= '0;
         first_lead <= 1'b0;
         out        <= 1'b1;
         rx_data    <= '0;
         rx_valid   <= 1'b0;
         abort      <= 1'b0;
      end else begin
         rx_valid <= frame_done;
         abort    <= abort_c;

         if (cs_fall) begin
            cpol_l <= cpol;
            cpha_l <= cpha;
            len_l  <= len;
         end

         // tx_ready is sampled before the consume, so a full buffer rejects the load
         if (tx_load && tx_ready) begin
            tx_buf   <= tx_data;
            tx_ready <= 1'b0;
         end else if (load_frame) begin
            tx_ready <= 1'b1;
         end

         if (frame_done)
            rx_data <= len_l ? rx_next : {8'h00, rx_next[7:0]};

         if (load_frame) begin
            tx_shift   <= load_word;
            bit_cnt    <= '0;
            first_lead <= 1'b1;
            if (!ent_cpha) out <= msb_of(load_word, ent_len);
         end else if (state == ACTIVE) begin
            if (sample_ev) begin
               rx_shift <= rx_next[DW-2:0];
               bit_cnt  <= bit_cnt + CW'(1);
            end
            // cpha=0: the trailing edge left over from the previous frame has bit_cnt=0
            if (shift_ev) begin
               if (cpha_l && first_lead) begin
                  out        <= msb_of(tx_shift, len_l);
                  first_lead <= 1'b0;
               end else if (cpha_l || (bit_cnt != '0)) begin
                  tx_shift <= tx_shifted;
                  out      <= msb_of(tx_shifted, len_l);
               end
            end
         end else if (state == IDLE) begin
            out <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_spi_follower.sv
// Directed bench for spi_follower: a behavioural SPI leader drives frames in
// each mode and checks MISO, rx_data and the rx_valid/abort pulses.
`timescale 1ns/1ps
module tb_spi_follower;
   localparam int HALF = 80;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        sclk = 1'b0;
   logic        cs_n = 1'b1;
   logic        mosi = 1'b0;
   logic        miso;
   logic        cpol = 1'b0;
   logic        cpha = 1'b0;
   logic        len = 1'b0;
   logic [15:0] tx_data = '0;
   logic        tx_load = 1'b0;
   logic        tx_ready;
   logic [15:0] rx_data;
   logic        rx_valid;
   logic        abort;

   int vectors = 0;
   int errors  = 0;
   int rx_cnt  = 0;
   int ab_cnt  = 0;
   logic [15:0] last_rx = '0;

   spi_follower #(.SYNC_STAGES(2)) dut (
      .clk(clk), .rst(rst), .ext_clk(sclk), .cs(cs_n), .in(mosi), .out(miso),
      .cpol(cpol), .cpha(cpha), .len(len), .tx_data(tx_data), .tx_load(tx_load),
      .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid), .abort(abort)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (rx_valid) begin
         rx_cnt  <= rx_cnt + 1;
         last_rx <= rx_data;
      end
      if (abort) ab_cnt <= ab_cnt + 1;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic load(input logic [15:0] w);
      tx_data = w;
      tx_load = 1'b1;
      #10;
      tx_load = 1'b0;
   endtask

   // Leader side of nbits bits; cs is not touched except for cs_last (cs rises with final trail)
   task automatic xfer_bits(input logic p, input logic h, input int nbits,
                            input logic [15:0] mosi_w, input logic mid_load,
                            input logic [15:0] mid_word, input logic cs_last,
                            output logic [15:0] miso_w);
      miso_w = '0;
      for (int i = nbits - 1; i >= 0; i--) begin
         if (!h) begin
            mosi = mosi_w[i];
            #HALF; sclk = ~p;
            miso_w = {miso_w[14:0], miso};
            #HALF; sclk = p;
         end else begin
            #HALF; sclk = ~p;
            mosi = mosi_w[i];
            #HALF; sclk = p;
            if (cs_last && i == 0) cs_n = 1'b1;
            miso_w = {miso_w[14:0], miso};
         end
         if (mid_load && i == nbits - 4) load(mid_word);
      end
   endtask

   task automatic frame(input logic p, input logic h, input logic l,
                        input logic [15:0] mosi_w, output logic [15:0] miso_w);
      cpol = p; cpha = h; len = l; sclk = p;
      #HALF;
      cs_n = 1'b0;
      xfer_bits(p, h, l ? 16 : 8, mosi_w, 1'b0, 16'h0, 1'b0, miso_w);
      #HALF;
      cs_n = 1'b1;
      #(3 * HALF);
   endtask

   task automatic test_reset();
      #23 rst = 1'b0;
      #200;
      @(negedge clk);
      vectors++; if (miso !== 1'b1) begin errors++; $display("FAIL reset_out got %b exp 1", miso); end
      vectors++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL reset_tx_ready got %b exp 1", tx_ready); end
      vectors++; if (rx_data !== 16'h0) begin errors++; $display("FAIL reset_rx_data got %h exp 0000", rx_data); end
      vectors++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid got %b exp 0", rx_valid); end
      vectors++; if (abort !== 1'b0) begin errors++; $display("FAIL reset_abort got %b exp 0", abort); end
   endtask

   task automatic test_mode0();
      logic [15:0] m;
      int r0, a0;
      r0 = rx_cnt; a0 = ab_cnt;
      load(16'h00A5);
      vectors++; if (tx_ready !== 1'b0) begin errors++; $display("FAIL m0_tx_ready got %b exp 0", tx_ready); end
      frame(1'b0, 1'b0, 1'b0, 16'h003C, m);
      vectors++; if (m !== 16'h00A5) begin errors++; $display("FAIL m0_miso got %h exp 00a5", m); end
      vectors++; if (rx_data !== 16'h003C) begin errors++; $display("FAIL m0_rx_data got %h exp 003c", rx_data); end
      vectors++; if (rx_cnt - r0 != 1) begin errors++; $display("FAIL m0_rx_valid got %0d exp 1", rx_cnt - r0); end
      vectors++; if (ab_cnt - a0 != 0) begin errors++; $display("FAIL m0_abort got %0d exp 0", ab_cnt - a0); end
   endtask

   task automatic test_mode3_16();
      logic [15:0] m;
      int r0;
      r0 = rx_cnt;
      load(16'h1234);
      frame(1'b1, 1'b1, 1'b1, 16'hBEEF, m);
      vectors++; if (m !== 16'h1234) begin errors++; $display("FAIL m3_miso got %h exp 1234", m); end
      vectors++; if (rx_data !== 16'hBEEF) begin errors++; $display("FAIL m3_rx_data got %h exp beef", rx_data); end
      vectors++; if (rx_cnt - r0 != 1) begin errors++; $display("FAIL m3_rx_valid got %0d exp 1", rx_cnt - r0); end
   endtask

   task automatic test_back_to_back();
      logic [15:0] m1, m2;
      int r0, a0;
      r0 = rx_cnt; a0 = ab_cnt;
      load(16'h0011);
      cpol = 1'b0; cpha = 1'b0; len = 1'b0; sclk = 1'b0;
      #HALF;
      cs_n = 1'b0;
      xfer_bits(1'b0, 1'b0, 8, 16'h00C3, 1'b1, 16'h0022, 1'b0, m1);
      vectors++; if (last_rx !== 16'h00C3) begin errors++; $display("FAIL b2b_rx1 got %h exp 00c3", last_rx); end
      xfer_bits(1'b0, 1'b0, 8, 16'h005A, 1'b0, 16'h0, 1'b0, m2);
      #HALF;
      cs_n = 1'b1;
      #(3 * HALF);
      vectors++; if (m1 !== 16'h0011) begin errors++; $display("FAIL b2b_miso1 got %h exp 0011", m1); end
      vectors++; if (m2 !== 16'h0022) begin errors++; $display("FAIL b2b_miso2 got %h exp 0022", m2); end
      vectors++; if (rx_data !== 16'h005A) begin errors++; $display("FAIL b2b_rx2 got %h exp 005a", rx_data); end
      vectors++; if (rx_cnt - r0 != 2) begin errors++; $display("FAIL b2b_rx_valid got %0d exp 2", rx_cnt - r0); end
      vectors++; if (ab_cnt - a0 != 0) begin errors++; $display("FAIL b2b_abort got %0d exp 0", ab_cnt - a0); end
   endtask

   task automatic test_underrun();
      logic [15:0] m;
      frame(1'b0, 1'b0, 1'b0, 16'h0096, m);
      vectors++; if (m !== 16'h0000) begin errors++; $display("FAIL ur_miso got %h exp 0000", m); end
      vectors++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL ur_tx_ready got %b exp 1", tx_ready); end
      vectors++; if (rx_data !== 16'h0096) begin errors++; $display("FAIL ur_rx_data got %h exp 0096", rx_data); end
   endtask

   task automatic test_abort();
      logic [15:0] m;
      int r0, a0;
      r0 = rx_cnt; a0 = ab_cnt;
      cpol = 1'b0; cpha = 1'b0; len = 1'b0; sclk = 1'b0;
      #HALF;
      cs_n = 1'b0;
      xfer_bits(1'b0, 1'b0, 5, 16'h001F, 1'b0, 16'h0, 1'b0, m);
      #HALF;
      cs_n = 1'b1;
      #(3 * HALF);
      vectors++; if (ab_cnt - a0 != 1) begin errors++; $display("FAIL ab_abort got %0d exp 1", ab_cnt - a0); end
      vectors++; if (rx_cnt - r0 != 0) begin errors++; $display("FAIL ab_rx_valid got %0d exp 0", rx_cnt - r0); end
      vectors++; if (rx_data !== 16'h0096) begin errors++; $display("FAIL ab_rx_data got %h exp 0096", rx_data); end
   endtask

   task automatic test_load_busy();
      logic [15:0] m;
      load(16'h0055);
      load(16'h0099);
      vectors++; if (tx_ready !== 1'b0) begin errors++; $display("FAIL busy_tx_ready got %b exp 0", tx_ready); end
      frame(1'b0, 1'b0, 1'b0, 16'h0000, m);
      vectors++; if (m !== 16'h0055) begin errors++; $display("FAIL busy_miso got %h exp 0055", m); end
      vectors++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL busy_tx_ready_after got %b exp 1", tx_ready); end
   endtask

   task automatic test_cs_with_last();
      logic [15:0] m;
      int r0, a0;
      r0 = rx_cnt; a0 = ab_cnt;
      load(16'h00F0);
      cpol = 1'b0; cpha = 1'b1; len = 1'b0; sclk = 1'b0;
      #HALF;
      cs_n = 1'b0;
      xfer_bits(1'b0, 1'b1, 8, 16'h0081, 1'b0, 16'h0, 1'b1, m);
      #(3 * HALF);
      vectors++; if (m !== 16'h00F0) begin errors++; $display("FAIL csl_miso got %h exp 00f0", m); end
      vectors++; if (rx_data !== 16'h0081) begin errors++; $display("FAIL csl_rx_data got %h exp 0081", rx_data); end
      vectors++; if (rx_cnt - r0 != 1) begin errors++; $display("FAIL csl_rx_valid got %0d exp 1", rx_cnt - r0); end
      vectors++; if (ab_cnt - a0 != 0) begin errors++; $display("FAIL csl_abort got %0d exp 0", ab_cnt - a0); end
   endtask

   task automatic test_reset_mid();
      logic [15:0] m;
      int r0, a0;
      load(16'h00AA);
      cpol = 1'b0; cpha = 1'b0; len = 1'b0; sclk = 1'b0;
      #HALF;
      cs_n = 1'b0;
      xfer_bits(1'b0, 1'b0, 3, 16'h0005, 1'b0, 16'h0, 1'b0, m);
      r0 = rx_cnt; a0 = ab_cnt;
      rst = 1'b1;
      #20;
      vectors++; if (miso !== 1'b1) begin errors++; $display("FAIL rm_out got %b exp 1", miso); end
      vectors++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL rm_tx_ready got %b exp 1", tx_ready); end
      vectors++; if (rx_data !== 16'h0) begin errors++; $display("FAIL rm_rx_data got %h exp 0000", rx_data); end
      vectors++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL rm_rx_valid got %b exp 0", rx_valid); end
      vectors++; if (abort !== 1'b0) begin errors++; $display("FAIL rm_abort got %b exp 0", abort); end
      cs_n = 1'b1;
      sclk = 1'b0;
      #50;
      rst = 1'b0;
      #(4 * HALF);
      vectors++; if (ab_cnt - a0 != 0) begin errors++; $display("FAIL rm_abort_after got %0d exp 0", ab_cnt - a0); end
      vectors++; if (rx_cnt - r0 != 0) begin errors++; $display("FAIL rm_rx_valid_after got %0d exp 0", rx_cnt - r0); end
   endtask

   initial begin
      test_reset();
      @(negedge clk);
      test_mode0();
      test_mode3_16();
      test_back_to_back();
      test_underrun();
      test_abort();
      test_load_busy();
      test_cs_with_last();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
